// File: rtl/md_sched.sv
// Multiply/divide scheduler: drives the multicycle multdiv unit, stalls the
// pipeline while it runs, and shares the regfile write port with the W stage.
module md_sched #(
  parameter int RSTATUS_REG   = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5,
  parameter int TIMEOUT       = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  input  logic        w_we,
  input  logic [4:0]  w_reg,
  input  logic [31:0] w_data,
  output logic        w_hold,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        stall,
  output logic        md_timeout
);

  // state | meaning
  // IDLE  | write port passes W through; waiting for an issue
  // START | one-cycle start pulse to multdiv, counter cleared
  // BUSY  | waiting for RDY or timeout
  // PEND  | W took the port on the RDY cycle; commit buffered result
  typedef enum logic [1:0] {IDLE, START, BUSY, PEND} state_t;

  localparam logic [6:0] TIMEOUT_CNT = 7'(TIMEOUT);

  state_t      state, state_next;
  logic [31:0] a_q, b_q;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic [6:0]  cnt;
  logic [4:0]  pend_reg;
  logic [31:0] pend_data;
  logic        timeout_q;
  logic [4:0]  res_reg;
  logic [31:0] res_data;
  logic        cnt_done;

  assign md_a       = a_q;
  assign md_b       = b_q;
  assign md_timeout = timeout_q;
  assign stall      = (state != IDLE) || issue_valid;
  assign cnt_done   = (cnt + 7'd1) == TIMEOUT_CNT;

  always_comb begin
    res_reg  = rd_q;
    res_data = data_result;
    if (data_exception) begin
      res_reg  = 5'(RSTATUS_REG);
      res_data = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
    end
  end

  always_comb begin
    state_next       = state;
    ctrl_MULT        = 1'b0;
    ctrl_DIV         = 1'b0;
    w_hold           = 1'b0;
    ctrl_writeEnable = w_we && (w_reg != 5'd0);
    ctrl_writeReg    = w_reg;
    data_writeReg    = w_data;
    case (state)
      IDLE: begin
        if (issue_valid) state_next = START;
      end
      START: begin
        ctrl_MULT  = !is_div_q;
        ctrl_DIV   = is_div_q;
        state_next = BUSY;
      end
      BUSY: begin
        if (data_resultRDY) begin
          // W keeps the port when it also wants it; our result waits in PEND
          if (!w_we) begin
            ctrl_writeEnable = res_reg != 5'd0;
            ctrl_writeReg    = res_reg;
            data_writeReg    = res_data;
            state_next       = IDLE;
          end else begin
            state_next = PEND;
          end
        end else if (cnt_done) begin
          state_next = IDLE;
        end
      end
      PEND: begin
        w_hold           = 1'b1;
        ctrl_writeEnable = pend_reg != 5'd0;
        ctrl_writeReg    = pend_reg;
        data_writeReg    = pend_data;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      cnt       <= '0;
      pend_reg  <= '0;
      pend_data <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && issue_valid) begin
        a_q      <= issue_a;
        b_q      <= issue_b;
        rd_q     <= issue_rd;
        is_div_q <= issue_is_div;
      end
      if (state == START)     cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 7'd1;
      if (state == BUSY && data_resultRDY && w_we) begin
        pend_reg  <= res_reg;
        pend_data <= res_data;
      end
      if (state == BUSY && !data_resultRDY && cnt_done) timeout_q <= 1'b1;
    end
  end

endmodule
